// File: rtl/ls_exec_unit.sv
// Load/store execution unit: queues LSBuffer requests, issues loads to the
// MemController, extends returned load data and reports results to the ROB.
module ls_exec_unit #(
    parameter int DATA_W   = 32,
    parameter int ROB_ID_W = 4,
    parameter int QDEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                lsb_valid,
    output logic                lsb_ready,
    input  logic                lsb_is_store,
    input  logic [1:0]          lsb_size,
    input  logic                lsb_unsigned,
    input  logic [DATA_W-1:0]   lsb_base,
    input  logic [11:0]         lsb_offset,
    input  logic [DATA_W-1:0]   lsb_store_data,
    input  logic [ROB_ID_W-1:0] lsb_rob_id,
    output logic                rob_valid,
    output logic [ROB_ID_W-1:0] rob_id,
    output logic [DATA_W-1:0]   rob_value,
    output logic [DATA_W-1:0]   rob_addr,
    output logic                rob_misaligned,
    input  logic                mc_store_full,
    output logic                mc_load_req,
    output logic [1:0]          mc_load_size,
    output logic [DATA_W-1:0]   mc_load_addr,
    input  logic                mc_load_done,
    input  logic [DATA_W-1:0]   mc_load_data,
    input  logic                rollback
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, DRAIN} state_t;

    typedef struct packed {
        logic                is_store;
        logic [1:0]          size;
        logic                is_unsigned;
        logic [DATA_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
        logic [ROB_ID_W-1:0] rob_id;
    } entry_t;

    entry_t             queue_mem [QDEPTH];
    entry_t             head_e;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    state_t             state;
    state_t             state_next;
    logic               q_empty;
    logic               push;
    logic               pop;
    logic               head_mis;
    logic [DATA_W-1:0]  enq_addr;
    logic [DATA_W-1:0]  load_ext;

    assign head_e   = queue_mem[head];
    assign q_empty  = (count == '0);
    assign push     = lsb_valid && lsb_ready && !rollback;
    assign enq_addr = lsb_base + {{(DATA_W-12){lsb_offset[11]}}, lsb_offset};
    // Reserved size 3 is handled as a word everywhere.
    assign head_mis = ((head_e.size == 2'd1) && head_e.addr[0]) ||
                      (head_e.size[1] && (head_e.addr[1:0] != 2'b00));

    always_comb begin
        load_ext = mc_load_data;
        case (head_e.size)
            2'd0: load_ext = {{(DATA_W-8){mc_load_data[7] & ~head_e.is_unsigned}},
                              mc_load_data[7:0]};
            2'd1: load_ext = {{(DATA_W-16){mc_load_data[15] & ~head_e.is_unsigned}},
                              mc_load_data[15:0]};
            default: load_ext = mc_load_data;
        endcase
    end

    always_comb begin
        pop        = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (!rollback && !q_empty) begin
                    if (head_mis || (head_e.is_store && !mc_store_full))
                        pop = 1'b1;
                    else if (!head_e.is_store)
                        state_next = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                // Data arriving with a rollback is dropped; otherwise wait it out in DRAIN.
                if (mc_load_done) begin
                    state_next = IDLE;
                    pop        = !rollback;
                end else if (rollback) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (mc_load_done)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        if (rollback)
            count_next = '0;
        else
            count_next = count + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rdy && push) begin
            queue_mem[tail] <= '{is_store:    lsb_is_store,
                                 size:        lsb_size,
                                 is_unsigned: lsb_unsigned,
                                 addr:        enq_addr,
                                 data:        lsb_store_data,
                                 rob_id:      lsb_rob_id};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            lsb_ready      <= 1'b1;
            rob_valid      <= 1'b0;
            rob_id         <= '0;
            rob_value      <= '0;
            rob_addr       <= '0;
            rob_misaligned <= 1'b0;
            mc_load_req    <= 1'b0;
            mc_load_size   <= 2'd0;
            mc_load_addr   <= '0;
        end else if (rdy) begin
            rob_valid   <= 1'b0;
            mc_load_req <= 1'b0;
            state       <= state_next;
            count       <= count_next;
            lsb_ready   <= (count_next < CNT_W'(QDEPTH)) && (state_next != DRAIN);

            if (rollback) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (push)
                    tail <= tail + PTR_W'(1);
                if (pop)
                    head <= head + PTR_W'(1);
            end

            if (!rollback) begin
                case (state)
                    IDLE: begin
                        if (!q_empty) begin
                            if (head_mis) begin
                                rob_valid      <= 1'b1;
                                rob_misaligned <= 1'b1;
                                rob_id         <= head_e.rob_id;
                                rob_addr       <= head_e.addr;
                                rob_value      <= '0;
                            end else if (head_e.is_store) begin
                                if (!mc_store_full) begin
                                    rob_valid      <= 1'b1;
                                    rob_misaligned <= 1'b0;
                                    rob_id         <= head_e.rob_id;
                                    rob_addr       <= head_e.addr;
                                    rob_value      <= head_e.data;
                                end
                            end else begin
                                mc_load_req  <= 1'b1;
                                mc_load_addr <= head_e.addr;
                                mc_load_size <= head_e.size;
                            end
                        end
                    end
                    LOAD_WAIT: begin
                        if (mc_load_done) begin
                            rob_valid      <= 1'b1;
                            rob_misaligned <= 1'b0;
                            rob_id         <= head_e.rob_id;
                            rob_addr       <= head_e.addr;
                            rob_value      <= load_ext;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ls_exec_unit.sv
// Self-checking bench for ls_exec_unit: directed scenarios plus a randomized
// run checked against a request-level reference model.
module tb_ls_exec_unit;
    localparam int DATA_W   = 32;
    localparam int ROB_ID_W = 4;
    localparam int QDEPTH   = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                rdy;
    logic                lsb_valid;
    logic                lsb_ready;
    logic                lsb_is_store;
    logic [1:0]          lsb_size;
    logic                lsb_unsigned;
    logic [DATA_W-1:0]   lsb_base;
    logic [11:0]         lsb_offset;
    logic [DATA_W-1:0]   lsb_store_data;
    logic [ROB_ID_W-1:0] lsb_rob_id;
    logic                rob_valid;
    logic [ROB_ID_W-1:0] rob_id;
    logic [DATA_W-1:0]   rob_value;
    logic [DATA_W-1:0]   rob_addr;
    logic                rob_misaligned;
    logic                mc_store_full;
    logic                mc_load_req;
    logic [1:0]          mc_load_size;
    logic [DATA_W-1:0]   mc_load_addr;
    logic                mc_load_done;
    logic [DATA_W-1:0]   mc_load_data;
    logic                rollback;

    int passed = 0;
    int total  = 0;

    ls_exec_unit #(.DATA_W(DATA_W), .ROB_ID_W(ROB_ID_W), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .lsb_valid(lsb_valid), .lsb_ready(lsb_ready), .lsb_is_store(lsb_is_store),
        .lsb_size(lsb_size), .lsb_unsigned(lsb_unsigned), .lsb_base(lsb_base),
        .lsb_offset(lsb_offset), .lsb_store_data(lsb_store_data), .lsb_rob_id(lsb_rob_id),
        .rob_valid(rob_valid), .rob_id(rob_id), .rob_value(rob_value), .rob_addr(rob_addr),
        .rob_misaligned(rob_misaligned), .mc_store_full(mc_store_full),
        .mc_load_req(mc_load_req), .mc_load_size(mc_load_size), .mc_load_addr(mc_load_addr),
        .mc_load_done(mc_load_done), .mc_load_data(mc_load_data), .rollback(rollback)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_store;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  id;
    } req_t;

    req_t exp_q[$];

    function automatic int size_bytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] eff_addr(input logic [31:0] base, input logic [11:0] off);
        int off_s;
        off_s = (off >= 12'd2048) ? int'(off) - 4096 : int'(off);
        return base + 32'(off_s);
    endfunction

    function automatic logic [31:0] ext_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] raw);
        longint span;
        longint m;
        if (size_bytes(size) == 4) return raw;
        span = longint'(1) << (8 * size_bytes(size));
        m = longint'(raw) % span;
        if (!uns && m >= span / 2) m = m - span;
        return 32'(m);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lsb_valid = 1'b0; lsb_is_store = 1'b0; lsb_size = 2'd0; lsb_unsigned = 1'b0;
        lsb_base = '0; lsb_offset = '0; lsb_store_data = '0; lsb_rob_id = '0;
        mc_store_full = 1'b0; mc_load_done = 1'b0; mc_load_data = '0; rollback = 1'b0;
    endtask

    task automatic drive_req(input logic st, input logic [1:0] sz, input logic uns,
                             input logic [31:0] base, input logic [11:0] off,
                             input logic [31:0] data, input logic [3:0] id);
        lsb_valid = 1'b1; lsb_is_store = st; lsb_size = sz; lsb_unsigned = uns;
        lsb_base = base; lsb_offset = off; lsb_store_data = data; lsb_rob_id = id;
    endtask

    task automatic test_reset();
        total++;
        if ({rob_valid, mc_load_req, rob_misaligned, lsb_ready} !== 4'b0001)
            $display("FAIL reset_flags got %b want 0001",
                     {rob_valid, mc_load_req, rob_misaligned, lsb_ready});
        else passed++;
        total++;
        if ({rob_id, rob_value, rob_addr, mc_load_addr, mc_load_size} !== '0)
            $display("FAIL reset_regs got id=%h val=%h addr=%h mcaddr=%h mcsize=%h want 0",
                     rob_id, rob_value, rob_addr, mc_load_addr, mc_load_size);
        else passed++;
    endtask

    task automatic test_load_ext();
        logic [31:0] want [2];
        want[0] = 32'hFFFF_FF80;
        want[1] = 32'h0000_0080;
        for (int k = 0; k < 2; k++) begin
            drive_req(1'b0, 2'd0, k[0], 32'h1000, 12'hFFF, 32'h0, 4'd3);
            step();
            lsb_valid = 1'b0;
            step();
            total++;
            if ({mc_load_req, mc_load_addr, mc_load_size} !== {1'b1, 32'h0000_0FFF, 2'd0})
                $display("FAIL lb_issue got req=%b addr=%h size=%0d want 1 00000fff 0",
                         mc_load_req, mc_load_addr, mc_load_size);
            else passed++;
            step();
            step();
            mc_load_done = 1'b1; mc_load_data = 32'h0000_0080;
            step();
            mc_load_done = 1'b0;
            total++;
            if ({rob_valid, rob_value, rob_addr, rob_id} !== {1'b1, want[k], 32'h0000_0FFF, 4'd3})
                $display("FAIL lb_result uns=%0d got v=%b val=%h addr=%h id=%0d want val=%h",
                         k, rob_valid, rob_value, rob_addr, rob_id, want[k]);
            else passed++;
            step();
        end
    endtask

    task automatic test_store_full();
        drive_req(1'b1, 2'd2, 1'b0, 32'h2000, 12'd8, 32'hDEAD_BEEF, 4'd5);
        mc_store_full = 1'b1;
        step();
        lsb_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (rob_valid !== 1'b0)
                $display("FAIL sw_held cycle %0d got rob_valid=%b want 0", i, rob_valid);
            else passed++;
        end
        mc_store_full = 1'b0;
        step();
        total++;
        if ({rob_valid, rob_addr, rob_value, rob_misaligned, rob_id} !==
            {1'b1, 32'h2008, 32'hDEAD_BEEF, 1'b0, 4'd5})
            $display("FAIL sw_result got v=%b addr=%h val=%h mis=%b id=%0d want 1 2008 deadbeef 0 5",
                     rob_valid, rob_addr, rob_value, rob_misaligned, rob_id);
        else passed++;
        step();
        total++;
        if (rob_valid !== 1'b0)
            $display("FAIL sw_single_pulse got rob_valid=%b want 0", rob_valid);
        else passed++;
    endtask

    task automatic test_misaligned();
        drive_req(1'b0, 2'd2, 1'b0, 32'h1002, 12'd0, 32'h0, 4'd6);
        step();
        lsb_valid = 1'b0;
        step();
        total++;
        if ({rob_valid, rob_misaligned, rob_addr, rob_value, rob_id, mc_load_req} !==
            {1'b1, 1'b1, 32'h1002, 32'h0, 4'd6, 1'b0})
            $display("FAIL lw_misaligned got v=%b mis=%b addr=%h val=%h id=%0d req=%b want 1 1 1002 0 6 0",
                     rob_valid, rob_misaligned, rob_addr, rob_value, rob_id, mc_load_req);
        else passed++;
        step();
        total++;
        if (mc_load_req !== 1'b0)
            $display("FAIL lw_misaligned_noreq got req=%b want 0", mc_load_req);
        else passed++;
        drive_req(1'b0, 2'd1, 1'b0, 32'h1002, 12'd0, 32'h0, 4'd8);
        step();
        lsb_valid = 1'b0;
        step();
        total++;
        if ({mc_load_req, mc_load_addr, mc_load_size} !== {1'b1, 32'h1002, 2'd1})
            $display("FAIL lh_issue got req=%b addr=%h size=%0d want 1 1002 1",
                     mc_load_req, mc_load_addr, mc_load_size);
        else passed++;
        mc_load_done = 1'b1; mc_load_data = 32'hABCD_F00D;
        step();
        mc_load_done = 1'b0;
        total++;
        if ({rob_valid, rob_misaligned, rob_value, rob_id} !== {1'b1, 1'b0, 32'hFFFF_F00D, 4'd8})
            $display("FAIL lh_result got v=%b mis=%b val=%h id=%0d want 1 0 fffff00d 8",
                     rob_valid, rob_misaligned, rob_value, rob_id);
        else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        int  accepted = 0;
        int  budget   = 0;
        logic acc;
        mc_store_full = 1'b1;
        drive_req(1'b1, 2'd2, 1'b0, 32'h3000, 12'd0, 32'h100, 4'd1);
        while (accepted < QDEPTH && budget < 20) begin
            acc = lsb_ready;
            step();
            budget++;
            if (acc) begin
                accepted++;
                drive_req(1'b1, 2'd2, 1'b0, 32'h3000 + 32'(4 * accepted), 12'd0,
                          32'h100 + 32'(accepted), 4'(accepted + 1));
            end
        end
        total++;
        if (accepted !== QDEPTH)
            $display("FAIL b2b_accepts got %0d want %0d", accepted, QDEPTH);
        else passed++;
        step();
        total++;
        if ({lsb_ready, rob_valid} !== 2'b00)
            $display("FAIL b2b_full_ready got ready=%b rob_valid=%b want 0 0", lsb_ready, rob_valid);
        else passed++;
        mc_store_full = 1'b0;
        for (int i = 0; i <= QDEPTH; i++) begin
            acc = lsb_valid && lsb_ready;
            step();
            if (acc) lsb_valid = 1'b0;
            total++;
            if ({rob_valid, rob_id, rob_addr} !== {1'b1, 4'(i + 1), 32'h3000 + 32'(4 * i)})
                $display("FAIL b2b_order slot %0d got v=%b id=%0d addr=%h want id=%0d",
                         i, rob_valid, rob_id, rob_addr, i + 1);
            else passed++;
            if (i == 0) begin
                total++;
                if (lsb_ready !== 1'b1)
                    $display("FAIL b2b_ready_return got %b want 1", lsb_ready);
                else passed++;
            end
        end
        lsb_valid = 1'b0;
        step();
    endtask

    task automatic test_rollback();
        drive_req(1'b0, 2'd2, 1'b0, 32'h4000, 12'd0, 32'h0, 4'd2);
        step();
        lsb_valid = 1'b0;
        step();
        total++;
        if (mc_load_req !== 1'b1)
            $display("FAIL rb_issue got req=%b want 1", mc_load_req);
        else passed++;
        rollback = 1'b1;
        drive_req(1'b1, 2'd2, 1'b0, 32'h4100, 12'd0, 32'h55, 4'd4);
        step();
        rollback = 1'b0; lsb_valid = 1'b0;
        total++;
        if ({rob_valid, mc_load_req, lsb_ready} !== 3'b000)
            $display("FAIL rb_drain got v=%b req=%b ready=%b want 000",
                     rob_valid, mc_load_req, lsb_ready);
        else passed++;
        step();
        total++;
        if ({rob_valid, lsb_ready} !== 2'b00)
            $display("FAIL rb_drain_hold got v=%b ready=%b want 00", rob_valid, lsb_ready);
        else passed++;
        mc_load_done = 1'b1; mc_load_data = 32'hCAFE_CAFE;
        step();
        mc_load_done = 1'b0;
        total++;
        if ({rob_valid, lsb_ready} !== 2'b01)
            $display("FAIL rb_done got v=%b ready=%b want 01", rob_valid, lsb_ready);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({rob_valid, mc_load_req} !== 2'b00)
                $display("FAIL rb_flushed cycle %0d got v=%b req=%b want 00", i, rob_valid, mc_load_req);
            else passed++;
        end
        drive_req(1'b0, 2'd2, 1'b0, 32'h4004, 12'd0, 32'h0, 4'd7);
        step();
        lsb_valid = 1'b0;
        step();
        mc_load_done = 1'b1; mc_load_data = 32'h1234_5678;
        step();
        mc_load_done = 1'b0;
        total++;
        if ({rob_valid, rob_value, rob_addr, rob_id} !== {1'b1, 32'h1234_5678, 32'h4004, 4'd7})
            $display("FAIL rb_after_lw got v=%b val=%h addr=%h id=%0d want 1 12345678 4004 7",
                     rob_valid, rob_value, rob_addr, rob_id);
        else passed++;
        step();
    endtask

    task automatic test_async_reset();
        drive_req(1'b0, 2'd2, 1'b0, 32'h5000, 12'd0, 32'h0, 4'd9);
        step();
        lsb_valid = 1'b0;
        step();
        total++;
        if ({mc_load_req, mc_load_addr} !== {1'b1, 32'h5000})
            $display("FAIL ar_issue got req=%b addr=%h want 1 5000", mc_load_req, mc_load_addr);
        else passed++;
        #2 rst = 1'b0;
        #1;
        total++;
        if ({mc_load_req, mc_load_addr, rob_id, rob_value, rob_addr, lsb_ready} !==
            {1'b0, 32'h0, 4'd0, 32'h0, 32'h0, 1'b1})
            $display("FAIL ar_async got req=%b mcaddr=%h id=%0d val=%h addr=%h ready=%b want all 0, ready 1",
                     mc_load_req, mc_load_addr, rob_id, rob_value, rob_addr, lsb_ready);
        else passed++;
        #1 rst = 1'b1;
        mc_load_done = 1'b1; mc_load_data = 32'h0000_FFFF;
        step();
        mc_load_done = 1'b0;
        total++;
        if ({rob_valid, mc_load_req} !== 2'b00)
            $display("FAIL ar_done_ignored got v=%b req=%b want 00", rob_valid, mc_load_req);
        else passed++;
        step();
    endtask

    task automatic test_random();
        req_t        r;
        req_t        f;
        logic        acc;
        logic        full_now;
        logic        rdy_now;
        logic [31:0] ld_data = '0;
        logic [31:0] want_val;
        logic        want_mis;
        int          lat_cnt = 0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            rdy = ($urandom_range(0, 7) != 0);
            lsb_valid = (cyc < 700) && ($urandom_range(0, 2) != 0);
            lsb_is_store = 1'($urandom_range(0, 1));
            lsb_size = 2'($urandom_range(0, 3));
            lsb_unsigned = 1'($urandom_range(0, 1));
            lsb_base = $urandom;
            lsb_offset = 12'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                lsb_base[1:0] = 2'b00;
                lsb_offset[1:0] = 2'b00;
            end
            lsb_store_data = $urandom;
            lsb_rob_id = 4'($urandom);
            mc_store_full = ($urandom_range(0, 3) == 0);
            mc_load_done = rdy && (lat_cnt == 1);
            mc_load_data = mc_load_done ? ld_data : $urandom;
            acc = lsb_valid && lsb_ready && rdy;
            full_now = mc_store_full;
            rdy_now = rdy;
            r = '{is_store: lsb_is_store, size: lsb_size, uns: lsb_unsigned,
                  addr: eff_addr(lsb_base, lsb_offset), data: lsb_store_data, id: lsb_rob_id};
            step();
            if (!rdy_now) continue;
            if (lat_cnt > 0) lat_cnt--;
            if (rob_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rnd_unexpected_result id=%0d addr=%h", rob_id, rob_addr);
                end else begin
                    f = exp_q.pop_front();
                    want_mis = (f.addr % size_bytes(f.size)) != 0;
                    want_val = want_mis ? 32'h0 : f.is_store ? f.data : ext_load(f.size, f.uns, ld_data);
                    if ({rob_id, rob_addr, rob_value, rob_misaligned} !== {f.id, f.addr, want_val, want_mis}
                        || (f.is_store && !want_mis && full_now))
                        $display("FAIL rnd_result cyc %0d got id=%0d addr=%h val=%h mis=%b want id=%0d addr=%h val=%h mis=%b",
                                 cyc, rob_id, rob_addr, rob_value, rob_misaligned, f.id, f.addr, want_val, want_mis);
                    else passed++;
                end
            end
            if (mc_load_req) begin
                total++;
                if (exp_q.size() == 0)
                    $display("FAIL rnd_unexpected_load addr=%h", mc_load_addr);
                else if (exp_q[0].is_store || {mc_load_addr, mc_load_size} !== {exp_q[0].addr, exp_q[0].size})
                    $display("FAIL rnd_load_req got addr=%h size=%0d want addr=%h size=%0d store=%b",
                             mc_load_addr, mc_load_size, exp_q[0].addr, exp_q[0].size, exp_q[0].is_store);
                else passed++;
                ld_data = $urandom;
                lat_cnt = $urandom_range(1, 4);
            end
            if (acc) exp_q.push_back(r);
        end
        rdy = 1'b1;
        idle_inputs();
        total++;
        if (exp_q.size() != 0)
            $display("FAIL rnd_drain got %0d outstanding want 0", exp_q.size());
        else passed++;
    endtask

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        #2 rst = 1'b1;
        step();
        test_reset();
        test_load_ext();
        test_store_full();
        test_misaligned();
        test_back_to_back();
        test_rollback();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ls_exec_unit.md
Name: ls_exec_unit

Overview:
Parametrised load/store execution unit sitting between the LSBuffer, the ReorderBuffer and the MemController. It accepts requests from the LSBuffer through a small internal request queue with a valid/ready handshake. It computes effective addresses, detects misalignment, issues loads to the MemController and sign/zero-extends the returned data. Stores are forwarded to the ROB (address and data) once the MemController store buffer has room. On ROB roll-back it flushes all queued work and discards any load that is still in flight.

Parameters:
DATA_W, 32, data and address width in bits
ROB_ID_W, 4, ROB index width
QDEPTH, 4, request queue entries (power of two, >=2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
rdy  input  1  global enable; when 0, all state and outputs hold
lsb_valid  input  1  request present
lsb_ready  output  1  queue can accept (registered: count<QDEPTH and state!=DRAIN)
lsb_is_store  input  1  1=store, 0=load
lsb_size  input  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
lsb_unsigned  input  1  zero-extend load (LBU/LHU)
lsb_base  input  DATA_W  rs1 value
lsb_offset  input  12  immediate, sign-extended to DATA_W
lsb_store_data  input  DATA_W  rs2 value
lsb_rob_id  input  ROB_ID_W  destination ROB entry
rob_valid  output  1  one-cycle result pulse
rob_id  output  ROB_ID_W  ROB entry of result
rob_value  output  DATA_W  extended load data / raw store data
rob_addr  output  DATA_W  effective address
rob_misaligned  output  1  address misaligned for size; no memory access made
mc_store_full  input  1  MemController store buffer full
mc_load_req  output  1  one-cycle load request pulse
mc_load_size  output  2  size of requested load
mc_load_addr  output  DATA_W  load address
mc_load_done  input  1  load data valid this cycle
mc_load_data  input  DATA_W  right-aligned raw load data
rollback  input  1  ROB roll-back flag

Behaviour:
- Reset (rst=0, async): queue empty, state IDLE; rob_valid, mc_load_req, rob_misaligned = 0; rob_id, rob_value, rob_addr, mc_load_addr, mc_load_size = 0; lsb_ready = 1.
- Enqueue: on a rising edge with lsb_valid & lsb_ready, the queue stores {is_store, size, unsigned, addr = lsb_base + sext(lsb_offset) mod 2^DATA_W, store_data, rob_id}. Circular pointers wrap at QDEPTH. Enqueue and dequeue in the same cycle are both allowed; count is unchanged.
- Misaligned: size=1 with addr[0]=1, or size>=2 with addr[1:0]!=0.
- States: IDLE, LOAD_WAIT, DRAIN. rob_valid and mc_load_req default to 0 every cycle.
- IDLE with a non-empty queue, acting on the head entry:
  - Misaligned: rob_valid=1, rob_misaligned=1, rob_addr=addr, rob_value=0. Pop the entry. No MC access.
  - Store with mc_store_full=0: rob_valid=1, rob_value=store_data, rob_addr=addr, rob_misaligned=0. Pop the entry.
  - Store with mc_store_full=1: hold the entry; retry every cycle.
  - Load: mc_load_req=1 for one cycle with mc_load_addr and mc_load_size set. Go to LOAD_WAIT. The entry stays at the head.
- LOAD_WAIT on mc_load_done=1:
  - Byte: sign-extend bit 7 (or zero-extend if unsigned).
  - Half: sign-extend bit 15 (or zero-extend if unsigned).
  - Word: pass through.
  - Then rob_valid=1 with the extended value and addr; pop the entry; go to IDLE.
- Latency: a request enqueued at edge E into an empty IDLE unit produces rob_valid after edge E+1 (store or misaligned), or mc_load_req after edge E+1. A load result appears after the edge at which mc_load_done is sampled.
- Only one load is outstanding at a time.
- Rollback=1, which has priority over all other activity except DRAIN tracking:
  - Queue is cleared; rob_valid=0 and mc_load_req=0 on the next cycle; enqueue that cycle is ignored.
  - If LOAD_WAIT and mc_load_done=0: go to DRAIN.
  - If LOAD_WAIT and mc_load_done=1 in the same cycle: discard the data and go to IDLE.
  - Otherwise go to IDLE.
- DRAIN: lsb_ready=0; wait for mc_load_done, discard the data, go to IDLE. Further rollback pulses in DRAIN keep DRAIN.
- rdy=0: freeze everything, including the queue. Outputs hold their values (rob_valid is held, not re-pulsed semantics: the bench treats rdy=0 cycles as non-cycles).
- Full queue: lsb_ready=0. It returns to 1 on the cycle after a pop.

Test Plan:
- LB, lsb_base=0x1000, lsb_offset=0xFFF (-1), mc_load_data=0x00000080 after 3 cycles -> mc_load_addr=0x00000FFF, mc_load_size=0; rob_value=0xFFFFFF80. Same with lsb_unsigned=1 -> rob_value=0x00000080.
- SW, base=0x2000, offset=8, data=0xDEADBEEF, mc_store_full=1 for 4 cycles then 0 -> no rob_valid while full; one pulse with rob_addr=0x2008, rob_value=0xDEADBEEF.
- LW at addr 0x1002 -> rob_valid with rob_misaligned=1, mc_load_req never asserted. LH at 0x1002 -> normal load issued.
- Push QDEPTH+1 back-to-back stores with mc_store_full=1 -> lsb_ready drops after QDEPTH accepts. Release -> QDEPTH results in FIFO rob_id order, one per cycle.
- Load issued, rollback 1 cycle later, mc_load_done 2 cycles after that -> no rob_valid, lsb_ready=0 until the done cycle, then 1. A new LW afterwards returns the correct data.
- Assert rst low mid-LOAD_WAIT -> all outputs reset immediately (asynchronously). A subsequent mc_load_done is ignored.
